id_ex_stage: RTL and testbench

Pipeline register and operand-select stage that sits directly upstream of the 32-bit ALU. It decodes MIPS opcode/funct into the 4-bit ALU control code and forms the two ALU operands: register value, forwarded value, or extended immediate. It registers everything behind a valid/ready handshake so the ALU sees stable inputs for a whole cycle. Hazards and stalls are resolved here so the combinational ALU needs no knowledge of the pipeline.

---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes MIPS opcode/funct to ALU control and selects ALU operands.
// Optional macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB forwarding plus hold-snoop.
module id_ex_stage #(
    parameter int WORD_SIZE           = 32,
    parameter int CONTROL_SIGNAL_SIZE = 4,
    parameter int REG_ADDR_SIZE       = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    input  logic [5:0]                     opcode,
    input  logic [5:0]                     funct,
    input  logic [REG_ADDR_SIZE-1:0]       rs_addr,
    input  logic [REG_ADDR_SIZE-1:0]       rt_addr,
    input  logic [REG_ADDR_SIZE-1:0]       rd_addr,
    input  logic [WORD_SIZE-1:0]           rs_data,
    input  logic [WORD_SIZE-1:0]           rt_data,
    input  logic [15:0]                    imm16,
    input  logic                           exmem_wr_en,
    input  logic                           memwb_wr_en,
    input  logic [REG_ADDR_SIZE-1:0]       exmem_wr_addr,
    input  logic [REG_ADDR_SIZE-1:0]       memwb_wr_addr,
    input  logic [WORD_SIZE-1:0]           exmem_wr_data,
    input  logic [WORD_SIZE-1:0]           memwb_wr_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_SIZE-1:0]           alu_input_a,
    output logic [WORD_SIZE-1:0]           alu_input_b,
    output logic [CONTROL_SIGNAL_SIZE-1:0] alu_control,
    output logic [REG_ADDR_SIZE-1:0]       dest_addr,
    output logic                           reg_write,
    output logic                           err_unsupported
);
    localparam logic [CONTROL_SIGNAL_SIZE-1:0] CTRL_AND = CONTROL_SIGNAL_SIZE'(4'h0);
    localparam logic [CONTROL_SIGNAL_SIZE-1:0] CTRL_OR  = CONTROL_SIGNAL_SIZE'(4'h1);
    localparam logic [CONTROL_SIGNAL_SIZE-1:0] CTRL_ADD = CONTROL_SIGNAL_SIZE'(4'h2);
    localparam logic [CONTROL_SIGNAL_SIZE-1:0] CTRL_ADU = CONTROL_SIGNAL_SIZE'(4'h3);
    localparam logic [CONTROL_SIGNAL_SIZE-1:0] CTRL_SUB = CONTROL_SIGNAL_SIZE'(4'h6);
    localparam logic [CONTROL_SIGNAL_SIZE-1:0] CTRL_SLT = CONTROL_SIGNAL_SIZE'(4'h7);
    localparam logic [CONTROL_SIGNAL_SIZE-1:0] CTRL_NOR = CONTROL_SIGNAL_SIZE'(4'hC);
    localparam logic [CONTROL_SIGNAL_SIZE-1:0] CTRL_BAD = CONTROL_SIGNAL_SIZE'(4'hF);

    logic [CONTROL_SIGNAL_SIZE-1:0] dec_ctrl;
    logic                           dec_unsup;
    logic                           dec_use_imm;
    logic                           dec_sext;
    logic [REG_ADDR_SIZE-1:0]       dec_dest;
    logic [WORD_SIZE-1:0]           imm_ext;
    logic [WORD_SIZE-1:0]           src_a, src_b;
    logic [WORD_SIZE-1:0]           snoop_a, snoop_b;
    logic                           capture;
    logic                           rw_q, err_q, b_is_reg;
    logic [REG_ADDR_SIZE-1:0]       held_rs_addr, held_rt_addr;

    always_comb begin
        dec_ctrl    = CTRL_BAD;
        dec_unsup   = 1'b1;
        dec_use_imm = 1'b0;
        dec_sext    = 1'b0;
        if (opcode == 6'h00) begin
            dec_unsup = 1'b0;
            case (funct)
                6'h20:   dec_ctrl = CTRL_ADD;
                6'h21:   dec_ctrl = CTRL_ADU;
                6'h22:   dec_ctrl = CTRL_SUB;
                6'h24:   dec_ctrl = CTRL_AND;
                6'h25:   dec_ctrl = CTRL_OR;
                6'h27:   dec_ctrl = CTRL_NOR;
                6'h2A:   dec_ctrl = CTRL_SLT;
                default: dec_unsup = 1'b1;
            endcase
        end else begin
            dec_unsup   = 1'b0;
            dec_use_imm = 1'b1;
            dec_sext    = 1'b1;
            case (opcode)
                6'h08:   dec_ctrl = CTRL_ADD;
                6'h09:   dec_ctrl = CTRL_ADU;
                6'h0A:   dec_ctrl = CTRL_SLT;
                6'h0C: begin dec_ctrl = CTRL_AND; dec_sext = 1'b0; end
                6'h0D: begin dec_ctrl = CTRL_OR;  dec_sext = 1'b0; end
                default: begin dec_unsup = 1'b1; dec_use_imm = 1'b0; end
            endcase
        end
    end

    // Unsupported R-type words still carry rd; every other format writes rt.
    assign dec_dest = (opcode == 6'h00) ? rd_addr : rt_addr;
    assign imm_ext  = dec_sext ? {{(WORD_SIZE-16){imm16[15]}}, imm16}
                               : {{(WORD_SIZE-16){1'b0}}, imm16};

`ifdef ID_EX_FORWARD_EN
    function automatic logic [WORD_SIZE-1:0] pick(input logic [REG_ADDR_SIZE-1:0] addr,
                                                  input logic [WORD_SIZE-1:0] cur);
        pick = cur;
        if (addr != '0) begin
            if (exmem_wr_en && exmem_wr_addr == addr)      pick = exmem_wr_data;
            else if (memwb_wr_en && memwb_wr_addr == addr) pick = memwb_wr_data;
        end
    endfunction

    always_comb begin
        src_a   = pick(rs_addr, rs_data);
        src_b   = dec_use_imm ? imm_ext : pick(rt_addr, rt_data);
        snoop_a = pick(held_rs_addr, alu_input_a);
        snoop_b = pick(held_rt_addr, alu_input_b);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_wr_en, memwb_wr_en, exmem_wr_addr, memwb_wr_addr,
                          exmem_wr_data, memwb_wr_data, held_rs_addr, held_rt_addr};
    always_comb begin
        src_a   = rs_data;
        src_b   = dec_use_imm ? imm_ext : rt_data;
        snoop_a = alu_input_a;
        snoop_b = alu_input_b;
    end
`endif

    // Handshake: a transfer happens on an edge where valid && ready are both high;
    // valid never drops without a transfer or flush, and the slot accepts when empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            alu_input_a  <= '0;
            alu_input_b  <= '0;
            alu_control  <= '0;
            dest_addr    <= '0;
            rw_q         <= 1'b0;
            err_q        <= 1'b0;
            b_is_reg     <= 1'b0;
            held_rs_addr <= '0;
            held_rt_addr <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid    <= 1'b1;
            alu_input_a  <= src_a;
            alu_input_b  <= src_b;
            alu_control  <= dec_ctrl;
            dest_addr    <= dec_dest;
            rw_q         <= !dec_unsup && (dec_dest != '0);
            err_q        <= dec_unsup;
            b_is_reg     <= !dec_use_imm;
            held_rs_addr <= rs_addr;
            held_rt_addr <= rt_addr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            // Stalled: keep register operands current with results retiring downstream.
            alu_input_a <= snoop_a;
            if (b_is_reg) alu_input_b <= snoop_b;
        end
    end

    assign reg_write       = out_valid && rw_q;
    assign err_unsupported = out_valid && err_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations adapt to ID_EX_FORWARD_EN.
module tb_id_ex_stage;
    localparam int W = 32;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, flush;
    logic [5:0]    opcode, funct;
    logic [4:0]    rs_addr, rt_addr, rd_addr;
    logic [W-1:0]  rs_data, rt_data;
    logic [15:0]   imm16;
    logic          exmem_wr_en, memwb_wr_en;
    logic [4:0]    exmem_wr_addr, memwb_wr_addr;
    logic [W-1:0]  exmem_wr_data, memwb_wr_data;
    logic          out_valid, out_ready;
    logic [W-1:0]  alu_input_a, alu_input_b;
    logic [3:0]    alu_control;
    logic [4:0]    dest_addr;
    logic          reg_write, err_unsupported;

    int total = 0;
    int bad = 0;
    int consumed = 0;
    logic [3:0] exp_q[$];

    id_ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .opcode(opcode), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
        .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
        .exmem_wr_addr(exmem_wr_addr), .memwb_wr_addr(memwb_wr_addr),
        .exmem_wr_data(exmem_wr_data), .memwb_wr_data(memwb_wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .alu_control(alu_control),
        .dest_addr(dest_addr), .reg_write(reg_write), .err_unsupported(err_unsupported)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) consumed <= consumed + 1;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_r(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [W-1:0] rsd, input logic [W-1:0] rtd);
        in_valid = 1'b1; opcode = 6'h00; funct = f;
        rs_addr = rs; rt_addr = rt; rd_addr = rd; rs_data = rsd; rt_data = rtd; imm16 = 16'h1234;
    endtask

    task automatic drive_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [W-1:0] rsd, input logic [15:0] imm);
        in_valid = 1'b1; opcode = op; funct = 6'h3F;
        rs_addr = rs; rt_addr = rt; rd_addr = 5'd31; rs_data = rsd; rt_data = 32'hDEAD_BEEF; imm16 = imm;
    endtask

    task automatic quiet_wb();
        exmem_wr_en = 1'b0; memwb_wr_en = 1'b0;
        exmem_wr_addr = '0; memwb_wr_addr = '0; exmem_wr_data = '0; memwb_wr_data = '0;
    endtask

    task automatic drain();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; quiet_wb();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; quiet_wb();
        drive_r(6'h20, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (alu_input_a !== '0 || alu_input_b !== '0) begin bad++; $display("FAIL reset_ops got=%h/%h exp=0/0", alu_input_a, alu_input_b); end
        total++; if (alu_control !== 4'h0 || dest_addr !== 5'd0) begin bad++; $display("FAIL reset_ctrl got=%h/%0d exp=0/0", alu_control, dest_addr); end
        total++; if (reg_write !== 1'b0 || err_unsupported !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", reg_write, err_unsupported); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_add();
        drive_r(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
        total++; if (alu_input_a !== 32'd5 || alu_input_b !== 32'd7) begin bad++; $display("FAIL add_ops got=%0d/%0d exp=5/7", alu_input_a, alu_input_b); end
        total++; if (alu_control !== 4'h2 || dest_addr !== 5'd3 || reg_write !== 1'b1) begin bad++; $display("FAIL add_ctrl got=%h/%0d/%0b exp=2/3/1", alu_control, dest_addr, reg_write); end
        step();
        total++; if (out_valid !== 1'b0 || reg_write !== 1'b0) begin bad++; $display("FAIL add_consumed got=%0b/%0b exp=0/0", out_valid, reg_write); end
    endtask

    task automatic test_imm();
        drive_i(6'h08, 5'd1, 5'd5, 32'd10, 16'hFFFF);
        step();
        total++; if (alu_input_b !== 32'hFFFF_FFFF || alu_control !== 4'h2 || dest_addr !== 5'd5) begin bad++; $display("FAIL addi got=%h/%h/%0d exp=ffffffff/2/5", alu_input_b, alu_control, dest_addr); end
        drive_i(6'h0C, 5'd1, 5'd6, 32'd10, 16'hFFFF);
        step();
        total++; if (alu_input_b !== 32'h0000_FFFF || alu_control !== 4'h0 || dest_addr !== 5'd6) begin bad++; $display("FAIL andi got=%h/%h/%0d exp=0000ffff/0/6", alu_input_b, alu_control, dest_addr); end
        drive_i(6'h0A, 5'd1, 5'd0, 32'd10, 16'h8000);
        step();
        total++; if (alu_input_b !== 32'hFFFF_8000 || alu_control !== 4'h7 || reg_write !== 1'b0) begin bad++; $display("FAIL slti_r0 got=%h/%h/%0b exp=ffff8000/7/0", alu_input_b, alu_control, reg_write); end
        drive_i(6'h0D, 5'd1, 5'd7, 32'd10, 16'h8001);
        step();
        total++; if (alu_input_b !== 32'h0000_8001 || alu_control !== 4'h1 || reg_write !== 1'b1) begin bad++; $display("FAIL ori got=%h/%h/%0b exp=00008001/1/1", alu_input_b, alu_control, reg_write); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [5:0] fn_tab[8]  = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h26};
        logic [3:0] ctl_tab[8] = '{4'h2, 4'h3, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7, 4'hF};
        logic [3:0] exp_c;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_r(fn_tab[i], 5'd1, 5'd2, 5'd9, W'($urandom_range(0, 1000)), 32'd3);
            exp_q.push_back(ctl_tab[i]);
            step();
            total++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                bad++; $display("FAIL b2b_valid idx=%0d got=%0b exp=1", i, out_valid);
            end else begin
                exp_c = exp_q.pop_front();
                if (alu_control !== exp_c) begin bad++; $display("FAIL b2b_ctrl idx=%0d got=%h exp=%h", i, alu_control, exp_c); end
            end
        end
        total++; if (err_unsupported !== 1'b1 || reg_write !== 1'b0) begin bad++; $display("FAIL b2b_xor got=%0b/%0b exp=1/0", err_unsupported, reg_write); end
        drain();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_queue got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_forward();
        drive_r(6'h20, 5'd4, 5'd6, 5'd3, 32'd1, 32'd2);
        exmem_wr_en = 1'b1; exmem_wr_addr = 5'd4; exmem_wr_data = 32'd9;
        memwb_wr_en = 1'b1; memwb_wr_addr = 5'd4; memwb_wr_data = 32'd8;
        step();
        total++; if (alu_input_a !== (FWD ? 32'd9 : 32'd1)) begin bad++; $display("FAIL fwd_exmem got=%0d exp=%0d", alu_input_a, FWD ? 9 : 1); end
        drive_r(6'h20, 5'd4, 5'd6, 5'd3, 32'd1, 32'd2);
        exmem_wr_addr = 5'd5; memwb_wr_addr = 5'd6; memwb_wr_data = 32'h77;
        step();
        total++; if (alu_input_a !== 32'd1 || alu_input_b !== (FWD ? 32'h77 : 32'd2)) begin bad++; $display("FAIL fwd_memwb got=%h/%h exp=1/%h", alu_input_a, alu_input_b, FWD ? 32'h77 : 32'd2); end
        drive_r(6'h20, 5'd0, 5'd6, 5'd3, 32'd1, 32'd2);
        exmem_wr_addr = 5'd0; memwb_wr_en = 1'b0;
        step();
        total++; if (alu_input_a !== 32'd1) begin bad++; $display("FAIL fwd_r0 got=%0d exp=1", alu_input_a); end
        drive_i(6'h08, 5'd3, 5'd4, 32'd1, 16'h0010);
        exmem_wr_addr = 5'd4;
        step();
        total++; if (alu_input_b !== 32'h10) begin bad++; $display("FAIL fwd_imm got=%h exp=10", alu_input_b); end
        drain();
    endtask

    task automatic test_stall();
        int c0;
        drive_r(6'h22, 5'd1, 5'd2, 5'd7, 32'h22, 32'h11);
        step();
        out_ready = 1'b0;
        drive_r(6'h25, 5'd8, 5'd9, 5'd10, 32'hAA, 32'hBB);
        step();
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_input_b !== 32'h11) begin bad++; $display("FAIL stall_c1 got=%0b/%0b/%h exp=0/1/11", in_ready, out_valid, alu_input_b); end
        memwb_wr_en = 1'b1; memwb_wr_addr = 5'd2; memwb_wr_data = 32'h55;
        step();
        quiet_wb();
        total++; if (alu_input_b !== (FWD ? 32'h55 : 32'h11)) begin bad++; $display("FAIL stall_snoop got=%h exp=%h", alu_input_b, FWD ? 32'h55 : 32'h11); end
        step();
        total++; if (alu_input_a !== 32'h22 || alu_control !== 4'h6 || dest_addr !== 5'd7 || reg_write !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%h/%0d/%0b exp=22/6/7/1", alu_input_a, alu_control, dest_addr, reg_write); end
        c0 = consumed;
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        total++; if (out_valid !== 1'b0 || consumed != c0 + 1) begin bad++; $display("FAIL stall_release got=%0b/%0d exp=0/1", out_valid, consumed - c0); end
    endtask

    task automatic test_unsupported();
        drive_i(6'h23, 5'd1, 5'd5, 32'd4, 16'h0004);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || alu_control !== 4'hF || err_unsupported !== 1'b1 || reg_write !== 1'b0) begin bad++; $display("FAIL lw got=%0b/%h/%0b/%0b exp=1/f/1/0", out_valid, alu_control, err_unsupported, reg_write); end
        drain();
    endtask

    task automatic test_flush_reset();
        drive_r(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || reg_write !== 1'b0 || err_unsupported !== 1'b0) begin bad++; $display("FAIL flush_in got=%0b/%0b/%0b exp=0/0/0", out_valid, reg_write, err_unsupported); end
        drive_i(6'h23, 5'd1, 5'd5, 32'd4, 16'h0004);
        step();
        out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || err_unsupported !== 1'b0) begin bad++; $display("FAIL flush_held got=%0b/%0b exp=0/0", out_valid, err_unsupported); end
        drive_r(6'h2A, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0 || alu_input_a !== '0 || alu_input_b !== '0 || alu_control !== 4'h0 || dest_addr !== 5'd0 || reg_write !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_stall got=%0b/%h/%h/%h/%0d/%0b/%0b exp=0/0/0/0/0/0/1", out_valid, alu_input_a, alu_input_b, alu_control, dest_addr, reg_write, in_ready);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_back_to_back();
        test_forward();
        test_stall();
        test_unsupported();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
